// File: rtl/stopwatch_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | stopwatch_pkg : shared types and constants for stopwatch_ctrl    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package stopwatch_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    LAP   = 3'd3,
    OVF   = 3'd4
  } sw_state_t;

  function automatic logic all_max(input bcd_t a, input bcd_t b, input bcd_t c, input bcd_t d);
    return (a == BCD_MAX) && (b == BCD_MAX) && (c == BCD_MAX) && (d == BCD_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_sync_edge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | btn_sync_edge : 2-FF synchronizer with rising-edge pulse         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic rise
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  always_comb begin
    sync1_d = btn_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign rise = sync2_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | stopwatch_ctrl : run/pause/lap/clear sequencer and tick prescaler|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop_btn,
  input  logic       lap_clr_btn,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] d4,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic [3:0] disp_d1,
  output logic [3:0] disp_d2,
  output logic [3:0] disp_d3,
  output logic [3:0] disp_d4,
  output logic       running,
  output logic       ovf
);

  localparam int            PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  logic ss_rise, lc_rise;

  btn_sync_edge u_ss_sync (.clk(clk), .rst_n(reset), .btn_in(start_stop_btn), .rise(ss_rise));
  btn_sync_edge u_lc_sync (.clk(clk), .rst_n(reset), .btn_in(lap_clr_btn),    .rise(lc_rise));

  sw_state_t   state_q,   state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0] freeze_q,  freeze_d;
  logic        cnt_en_q,  cnt_en_d;
  logic        cnt_clr_q, cnt_clr_d;
  logic        running_q, running_d;
  logic        ovf_q,     ovf_d;

  logic active, tick, at_max;

  always_comb begin
    active   = (state_q == RUN) || (state_q == LAP);
    tick     = active && (presc_q == TICK_LAST);
    at_max   = all_max(d1, d2, d3, d4);
    state_d  = state_q;
    freeze_d = freeze_q;
    presc_d  = presc_q;

    if (active) presc_d = tick ? '0 : presc_q + PW'(1);

    // start_stop is tested first everywhere so a coincident lap_clr edge is dropped
    case (state_q)
      IDLE:  if (ss_rise) state_d = RUN;
      RUN: begin
        if (ss_rise) state_d = PAUSE;
        else if (lc_rise) begin
          state_d  = LAP;
          freeze_d = {d4, d3, d2, d1};
        end else if (tick && at_max) state_d = OVF;
      end
      LAP: begin
        if (ss_rise)             state_d = PAUSE;
        else if (lc_rise)        state_d = RUN;
        else if (tick && at_max) state_d = OVF;
      end
      PAUSE: begin
        if (ss_rise)      state_d = RUN;
        else if (lc_rise) state_d = IDLE;
      end
      OVF:     if (lc_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) presc_d = '0;

    // Saturate at 9999: the overflowing tick is swallowed instead of wrapping the chain
    cnt_en_d  = tick && !at_max;
    cnt_clr_d = (state_d == IDLE) && (state_q != IDLE);
    running_d = (state_d == RUN) || (state_d == LAP);
    ovf_d     = (state_d == OVF);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      freeze_q  <= '0;
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
      running_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      freeze_q  <= freeze_d;
      cnt_en_q  <= cnt_en_d;
      cnt_clr_q <= cnt_clr_d;
      running_q <= running_d;
      ovf_q     <= ovf_d;
    end
  end

  assign cnt_en  = cnt_en_q;
  assign cnt_clr = cnt_clr_q;
  assign running = running_q;
  assign ovf     = ovf_q;

  assign disp_d1 = (state_q == LAP) ? freeze_q[3:0]   : d1;
  assign disp_d2 = (state_q == LAP) ? freeze_q[7:4]   : d2;
  assign disp_d3 = (state_q == LAP) ? freeze_q[11:8]  : d3;
  assign disp_d4 = (state_q == LAP) ? freeze_q[15:12] : d4;

endmodule
`default_nettype wire
